// File: rtl/rf_arbiter.sv
// Two-requester round-robin arbiter in front of a register file with shared data buses.
// Latency: request seen in IDLE -> ACCESS next cycle -> ACK the cycle after, so one transaction per 3 cycles.
// Backpressure: a requester holds REQx until ACKx; the loser of a tie simply stays pending and wins next.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   REQx, WEx, ADDRx, WDATAx requester x access request (WE=1 write, 0 read), address, write data
//   ACKx, RDATAx             one-cycle completion pulse, read result held between reads
//   RF_WS, RF_RS             one-hot word write / read selects to the register file
//   RF_IN, RF_OUT            shared write-data bus out, shared read-data bus in
//   BUSY                     high while a transaction is in flight (state not IDLE)
module rf_arbiter #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ0,
  input  logic                    REQ1,
  input  logic                    WE0,
  input  logic                    WE1,
  input  logic [ADDR_W-1:0]       ADDR0,
  input  logic [ADDR_W-1:0]       ADDR1,
  input  logic [WIDTH-1:0]        WDATA0,
  input  logic [WIDTH-1:0]        WDATA1,
  output logic                    ACK0,
  output logic                    ACK1,
  output logic [WIDTH-1:0]        RDATA0,
  output logic [WIDTH-1:0]        RDATA1,
  output logic [(2**ADDR_W)-1:0]  RF_WS,
  output logic [(2**ADDR_W)-1:0]  RF_RS,
  output logic [WIDTH-1:0]        RF_IN,
  input  logic [WIDTH-1:0]        RF_OUT,
  output logic                    BUSY
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Transaction captured at grant time; requester inputs are ignored until the next IDLE.
  logic              lat_id;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [WIDTH-1:0]  lat_wdata;

  // Id of the most recent grantee. Resets to 1 so requester 0 wins the first tie.
  logic              last;

  logic              any_req;
  logic              grant_id;
  logic [DEPTH-1:0]  addr_dec;

  // Round-robin pick: a lone requester always wins; on a tie the one not granted last wins.
  always_comb begin
    any_req  = REQ0 | REQ1;
    grant_id = 1'b0;
    if (REQ0 && REQ1) begin
      grant_id = ~last;
    end else begin
      grant_id = REQ1;
    end
  end

  always_comb begin
    addr_dec           = '0;
    addr_dec[lat_addr] = 1'b1;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and register-file / handshake outputs. Strobes are masked while RST is
  // high so a reset landing on the ACCESS-ending edge never commits the word and a
  // reset in ACK never produces an acknowledge.
  always_comb begin
    state_nxt = state;
    ACK0      = 1'b0;
    ACK1      = 1'b0;
    RF_WS     = '0;
    RF_RS     = '0;
    RF_IN     = '0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_nxt = S_ACK;
        if (!RST) begin
          if (lat_we) begin
            RF_WS = addr_dec;
            RF_IN = lat_wdata;
          end else begin
            RF_RS = addr_dec;
          end
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
        if (!RST) begin
          ACK0 = ~lat_id;
          ACK1 = lat_id;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign BUSY = (state != S_IDLE);

  // Grant capture, round-robin pointer and per-requester read data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last      <= 1'b1;
      lat_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      RDATA0    <= '0;
      RDATA1    <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        last      <= grant_id;
        lat_id    <= grant_id;
        if (grant_id) begin
          lat_we    <= WE1;
          lat_addr  <= ADDR1;
          lat_wdata <= WDATA1;
        end else begin
          lat_we    <= WE0;
          lat_addr  <= ADDR0;
          lat_wdata <= WDATA0;
        end
      end
      // Only the grantee's read register moves; writes never touch either.
      if (state == S_ACCESS && !lat_we) begin
        if (lat_id) begin
          RDATA1 <= RF_OUT;
        end else begin
          RDATA0 <= RF_OUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_arbiter.sv
// Bench for rf_arbiter: register-file words modelled behind the shared buses, requester
// agents driving REQ/WE/ADDR/WDATA, and a transaction-level reference model compared
// against every output each cycle plus directed scenario checks.
module tb_rf_arbiter;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             RST, REQ0, REQ1, WE0, WE1;
  logic [2:0]       ADDR0, ADDR1;
  logic [7:0]       WDATA0, WDATA1;
  logic             ACK0, ACK1, BUSY;
  logic [7:0]       RDATA0, RDATA1, RF_IN, RF_OUT;
  logic [DEPTH-1:0] RF_WS, RF_RS;

  rf_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .RF_WS(RF_WS), .RF_RS(RF_RS), .RF_IN(RF_IN), .RF_OUT(RF_OUT),
    .BUSY(BUSY)
  );

  // Physical register-file words: store on W_S at the rising edge, drive the bus on R_S.
  logic [7:0] env_mem  [DEPTH];
  logic [7:0] init_mem [DEPTH];
  logic       env_load;

  always_comb begin
    RF_OUT = '0;
    for (int i = 0; i < DEPTH; i++) if (RF_RS[i]) RF_OUT = RF_OUT | env_mem[i];
  end

  always @(posedge CLK) begin
    if (env_load) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_mem[i];
    end else begin
      for (int i = 0; i < DEPTH; i++) if (RF_WS[i]) env_mem[i] <= RF_IN;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: one in-flight transaction identified by the cycle it was granted in.
  int         g_cyc = -100;
  bit         g_id, g_we;
  logic [2:0] g_addr;
  logic [7:0] g_wd;
  bit         last_id = 1'b1;
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] exp_rd  [2];

  // Requester agents.
  bit         pend [2];
  bit         pwe  [2];
  logic [2:0] paddr[2];
  logic [7:0] pwd  [2];
  bit         rst_i, hold_always, drop_grant, scramble;

  int ack_ids[$];
  int ack_cycs[$];
  int busy_cnt;

  task automatic set_req(input int id, input bit we, input logic [2:0] a, input logic [7:0] wd);
    pend[id] = 1'b1; pwe[id] = we; paddr[id] = a; pwd[id] = wd;
  endtask

  // One clock cycle: drive after the falling edge, check 1 time unit later, advance model.
  task automatic step(input bit chk);
    int d;
    bit r0, r1, w, exp_a0, exp_a1, exp_busy, onehot_ok;
    logic [7:0] exp_ws, exp_rs, exp_in;
    RST = rst_i;
    REQ0 = pend[0]; WE0 = pwe[0]; ADDR0 = paddr[0]; WDATA0 = pwd[0];
    REQ1 = pend[1]; WE1 = pwe[1]; ADDR1 = paddr[1]; WDATA1 = pwd[1];
    r0 = pend[0]; r1 = pend[1];
    #1;
    d = cyc - g_cyc;
    exp_busy = (d == 1) || (d == 2);
    exp_ws = '0; exp_rs = '0; exp_in = '0; exp_a0 = 1'b0; exp_a1 = 1'b0;
    if (!rst_i && d == 1) begin
      if (g_we) begin exp_ws = 8'(1) << g_addr; exp_in = g_wd; end
      else exp_rs = 8'(1) << g_addr;
    end
    if (!rst_i && d == 2) begin
      if (g_id) exp_a1 = 1'b1; else exp_a0 = 1'b1;
    end
    if (chk) begin
      check_val("busy",   BUSY,   exp_busy);
      check_val("ack0",   ACK0,   exp_a0);
      check_val("ack1",   ACK1,   exp_a1);
      check_val("rf_ws",  RF_WS,  exp_ws);
      check_val("rf_rs",  RF_RS,  exp_rs);
      check_val("rf_in",  RF_IN,  exp_in);
      check_val("rdata0", RDATA0, exp_rd[0]);
      check_val("rdata1", RDATA1, exp_rd[1]);
      onehot_ok = ($countones(RF_WS) <= 1) && ($countones(RF_RS) <= 1) && !((|RF_WS) && (|RF_RS));
      check_val("sel_onehot", onehot_ok, 1);
    end
    if (ACK0 === 1'b1) begin ack_ids.push_back(0); ack_cycs.push_back(cyc); end
    if (ACK1 === 1'b1) begin ack_ids.push_back(1); ack_cycs.push_back(cyc); end
    if (BUSY === 1'b1) busy_cnt++;

    if (rst_i) begin
      g_cyc = -100; last_id = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      pend[0] = 1'b0; pend[1] = 1'b0;
    end else begin
      if (d == 1) begin
        if (g_we) ref_mem[g_addr] = g_wd;
        else exp_rd[g_id] = ref_mem[g_addr];
      end
      if (d == 2 && !hold_always) pend[g_id] = 1'b0;
      if (d >= 3 && (r0 || r1)) begin
        if (r0 && r1) w = !last_id; else w = r1;
        last_id = w; g_id = w; g_cyc = cyc;
        g_we = pwe[w]; g_addr = paddr[w]; g_wd = pwd[w];
        if (drop_grant) pend[w] = 1'b0;
        else if (scramble) begin
          pwe[w] = 1'($urandom); paddr[w] = 3'($urandom); pwd[w] = 8'($urandom);
        end
      end
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b1);
  endtask

  task automatic clear_logs();
    ack_ids.delete(); ack_cycs.delete(); busy_cnt = 0;
  endtask

  initial begin
    int t0;
    int exp_order[4];
    logic [7:0] prev1, old6;
    exp_order = '{0, 1, 0, 1};
    rst_i = 1'b1; hold_always = 1'b0; drop_grant = 1'b0; scramble = 1'b0;
    for (int i = 0; i < 2; i++) begin pend[i] = 0; pwe[i] = 0; paddr[i] = '0; pwd[i] = '0; end
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      init_mem[i] = 8'($urandom);
      ref_mem[i]  = init_mem[i];
    end
    env_load = 1'b1;

    // Reset: the first cycle has no defined state yet; later reset cycles are checked.
    step(1'b0);
    step(1'b1);
    step(1'b1);
    env_load = 1'b0;
    rst_i = 1'b0;
    run(2);

    // Single write then read back of address 5.
    clear_logs();
    t0 = cyc;
    set_req(0, 1'b1, 3'd5, 8'hA5);
    run(4);
    check_val("wr_ack_count", ack_ids.size(), 1);
    if (ack_cycs.size() >= 1) check_val("wr_ack_latency", ack_cycs[0] - t0, 2);
    set_req(0, 1'b0, 3'd5, 8'h00);
    run(4);
    check_val("rd_a5_rdata0", RDATA0, 8'hA5);
    check_val("rd_a5_rdata1", RDATA1, 8'h00);

    // Contention after reset with both requests held continuously.
    rst_i = 1'b1; step(1'b1); step(1'b1); rst_i = 1'b0;
    clear_logs();
    t0 = cyc;
    hold_always = 1'b1;
    set_req(0, 1'b0, 3'd1, 8'h00);
    set_req(1, 1'b0, 3'd3, 8'h00);
    run(12);
    hold_always = 1'b0;
    check_val("cont_ack_count", ack_ids.size(), 4);
    for (int i = 0; i < 4 && i < ack_ids.size(); i++) check_val("cont_grant_order", ack_ids[i], exp_order[i]);
    if (ack_cycs.size() >= 1) check_val("cont_first_ack", ack_cycs[0] - t0, 2);
    for (int i = 1; i < ack_cycs.size(); i++) check_val("cont_ack_spacing", ack_cycs[i] - ack_cycs[i-1], 3);
    pend[0] = 1'b0; pend[1] = 1'b0;
    run(4);

    // Requester 1 writes, requester 0 reads the same word.
    set_req(1, 1'b1, 3'd2, 8'h3C);
    run(4);
    prev1 = exp_rd[1];
    set_req(0, 1'b0, 3'd2, 8'h00);
    run(4);
    check_val("xport_rdata0", RDATA0, 8'h3C);
    check_val("xport_rdata1", RDATA1, prev1);

    // One-cycle request pulse still completes exactly once.
    clear_logs();
    drop_grant = 1'b1;
    set_req(1, 1'b0, 3'd4, 8'h00);
    run(6);
    drop_grant = 1'b0;
    check_val("drop_ack_count", ack_ids.size(), 1);
    if (ack_ids.size() >= 1) check_val("drop_ack_id", ack_ids[0], 1);
    check_val("drop_busy_cycles", busy_cnt, 2);

    // Reset landing in a write ACCESS aborts it without committing the word.
    old6 = ref_mem[6];
    set_req(0, 1'b1, 3'd6, ~old6);
    step(1'b1);
    rst_i = 1'b1;
    clear_logs();
    step(1'b1);
    rst_i = 1'b0;
    run(3);
    check_val("rst_access_acks", ack_ids.size(), 0);
    set_req(0, 1'b0, 3'd6, 8'h00);
    run(4);
    check_val("rst_access_old_value", RDATA0, old6);

    // Address sweep with writes and reads from alternating requesters.
    for (int a = 0; a < DEPTH; a++) begin
      set_req(a % 2, 1'b1, 3'(a), 8'($urandom));
      run(4);
      set_req((a + 1) % 2, 1'b0, 3'(a), 8'h00);
      run(4);
    end

    // Random traffic with input scrambling after grant and occasional resets.
    scramble = 1'b1;
    repeat (400) begin
      for (int x = 0; x < 2; x++)
        if (!pend[x] && $urandom_range(0, 2) == 0)
          set_req(x, 1'($urandom), 3'($urandom_range(0, 7)), 8'($urandom));
      rst_i = ($urandom_range(0, 99) == 0);
      step(1'b1);
    end
    rst_i = 1'b0;
    scramble = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
